// File: rtl/gpio_input_debounce_if.sv
// Signal bundle between the pad-side conditioning stage and its consumer.
// The slave modport is the debounce block; the master modport is whoever drives
// the pads/configuration and consumes the conditioned levels and edge pulses.
interface gpio_input_debounce_if #(
  parameter int unsigned NrGPIOs  = 64,
  parameter int unsigned CntWidth = 16
);
  logic [NrGPIOs-1:0]  gpio_pad_i;
  logic [NrGPIOs-1:0]  filter_en_i;
  logic [CntWidth-1:0] debounce_cycles_i;
  logic [NrGPIOs-1:0]  gpio_o;
  logic [NrGPIOs-1:0]  rise_o;
  logic [NrGPIOs-1:0]  fall_o;

  modport master (
    output gpio_pad_i, filter_en_i, debounce_cycles_i,
    input  gpio_o, rise_o, fall_o
  );

  modport slave (
    input  gpio_pad_i, filter_en_i, debounce_cycles_i,
    output gpio_o, rise_o, fall_o
  );
endinterface

// File: rtl/gpio_input_debounce.sv
// Per-pin GPIO input conditioning: optional two-flop synchroniser, glitch filter
// with programmable stability threshold, and registered one-cycle edge pulses.
// Build option: define GPIO_DEBOUNCE_SYNC_EN to insert the two-flop synchroniser
// in front of the filter; leave it undefined when the pads are already synchronous.
module gpio_input_debounce #(
  parameter int unsigned NrGPIOs  = 64,
  parameter int unsigned CntWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  gpio_input_debounce_if.slave  dbnc
);

  logic [NrGPIOs-1:0]  s;        // sampled pad level seen by the filter
  logic [NrGPIOs-1:0]  q_q;      // accepted (debounced) level
  logic [NrGPIOs-1:0]  q_d;
  logic [NrGPIOs-1:0]  rise_q;
  logic [NrGPIOs-1:0]  fall_q;
  logic [CntWidth-1:0] thresh_m1; // Neff-1, with a zero threshold treated as 1

  assign thresh_m1 = (dbnc.debounce_cycles_i == '0) ? '0
                                                    : dbnc.debounce_cycles_i - 1'b1;

`ifdef GPIO_DEBOUNCE_SYNC_EN
  logic [NrGPIOs-1:0] sync1_q;
  logic [NrGPIOs-1:0] sync2_q;

  // Two-flop synchroniser for fully asynchronous pad inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dbnc.gpio_pad_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = dbnc.gpio_pad_i;
`endif

  // Each pin owns its stability counter; pins never interact.
  for (genvar gi = 0; gi < NrGPIOs; gi++) begin : g_pin
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;
    logic                q_pin_d;

    // Next-state: bypass follows s; otherwise s must differ from q for Neff
    // consecutive cycles. The '>=' lets a lowered threshold commit immediately.
    always_comb begin
      q_pin_d = q_q[gi];
      cnt_d   = '0;
      if (!dbnc.filter_en_i[gi]) begin
        q_pin_d = s[gi];
      end else if (s[gi] != q_q[gi]) begin
        if (cnt_q >= thresh_m1) begin
          q_pin_d = s[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Stability counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign q_d[gi] = q_pin_d;
  end

  // Debounced level plus edge pulses, registered together so each pulse lines
  // up with the cycle in which gpio_o first shows the new level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      q_q    <= q_d;
      rise_q <= ~q_q & q_d;
      fall_q <= q_q & ~q_d;
    end
  end

  assign dbnc.gpio_o = q_q;
  assign dbnc.rise_o = rise_q;
  assign dbnc.fall_o = fall_q;

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Self-checking bench for gpio_input_debounce: directed scenarios plus a
// randomized phase, all compared against a cycle-level reference model.
module tb_gpio_input_debounce;
  localparam int NG = 64;
  localparam int CW = 16;
`ifdef GPIO_DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NG-1:0] pad = '0;
  logic [NG-1:0] en  = '1;
  logic [CW-1:0] ncyc = 16'd4;

  gpio_input_debounce_if #(.NrGPIOs(NG), .CntWidth(CW)) bus ();
  assign bus.gpio_pad_i        = pad;
  assign bus.filter_en_i       = en;
  assign bus.debounce_cycles_i = ncyc;

  gpio_input_debounce #(.NrGPIOs(NG), .CntWidth(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .dbnc   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: pad history (synchroniser delay), accepted level, and the
  // number of consecutive sampled cycles the input has disagreed with it.
  logic [NG-1:0] m_q, m_rise, m_fall;
  logic [NG-1:0] hist [2];
  int            run  [NG];

  task automatic chk(input string tag, input logic [NG-1:0] obs, input logic [NG-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = '0; m_rise = '0; m_fall = '0;
    hist[0] = '0; hist[1] = '0;
    for (int i = 0; i < NG; i++) run[i] = 0;
  endtask

  task automatic model_edge();
    logic [NG-1:0] s, qn;
    int neff;
    if (SL == 2) begin
      s = hist[1];
      hist[1] = hist[0];
      hist[0] = pad;
    end else begin
      s = pad;
    end
    neff = (ncyc == 0) ? 1 : int'(ncyc);
    qn = m_q;
    for (int i = 0; i < NG; i++) begin
      if (!en[i]) begin
        qn[i] = s[i];
        run[i] = 0;
      end else if (s[i] == m_q[i]) begin
        run[i] = 0;
      end else begin
        run[i] = run[i] + 1;
        if (run[i] >= neff) begin
          qn[i] = s[i];
          run[i] = 0;
        end
      end
    end
    m_rise = ~m_q & qn;
    m_fall = m_q & ~qn;
    m_q = qn;
  endtask

  // One clock edge: advance the model, then compare all outputs 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".gpio"}, bus.gpio_o, m_q);
    chk({tag, ".rise"}, bus.rise_o, m_rise);
    chk({tag, ".fall"}, bus.fall_o, m_fall);
  endtask

  // Asynchronous reset pulse in mid-cycle; released just after the next edge.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.gpio", bus.gpio_o, '0);
    chk("rst.rise", bus.rise_o, '0);
    chk("rst.fall", bus.fall_o, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [NG-1:0] stim  [40];
  logic [NG-1:0] wave0 [40];
  logic          p7_hist [64];
  logic          pulse3;

  initial begin
    model_reset();
    for (int i = 0; i < 40; i++) stim[i] = {$urandom, $urandom};

    // Reset state.
    @(posedge clk);
    #1;
    do_reset();

    // 1: single pin rises with N=4; commits exactly at edge Neff+SL.
    pad = '0; ncyc = 16'd4; en = '1;
    for (int k = 0; k < 3; k++) step("t1.idle");
    pad[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step("t1");
      if (k == 3 + SL) chk("t1.before", {63'd0, bus.gpio_o[0]}, 64'd0);
      if (k == 4 + SL) chk("t1.edge", {62'd0, bus.gpio_o[0], bus.rise_o[0]}, 64'd3);
      if (k == 5 + SL) chk("t1.after", {63'd0, bus.rise_o[0]}, 64'd0);
    end

    // 2: glitch of 3 cycles with N=4 is discarded.
    do_reset();
    pad = '0; ncyc = 16'd4;
    pulse3 = 1'b0;
    step("t2.idle");
    pad[3] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("t2.hi");
      pulse3 = pulse3 | bus.rise_o[3] | bus.fall_o[3];
    end
    pad[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step("t2.lo");
      pulse3 = pulse3 | bus.rise_o[3] | bus.fall_o[3];
    end
    chk("t2.level", {63'd0, bus.gpio_o[3]}, 64'd0);
    chk("t2.pulse", {63'd0, pulse3}, 64'd0);

    // 3: N=0 and N=1 give identical waveforms for the same stimulus.
    do_reset();
    ncyc = 16'd0;
    for (int k = 0; k < 40; k++) begin
      pad = stim[k];
      step("t3.n0");
      wave0[k] = bus.gpio_o;
    end
    do_reset();
    ncyc = 16'd1;
    for (int k = 0; k < 40; k++) begin
      pad = stim[k];
      step("t3.n1");
      chk("t3.same", bus.gpio_o, wave0[k]);
    end

    // 4: lowering N mid-count commits a long-pending pin on the next edge.
    do_reset();
    pad = '0; ncyc = 16'd1000;
    pad[5] = 1'b1;
    for (int k = 0; k < 500; k++) step("t4.wait");
    chk("t4.pending", {63'd0, bus.gpio_o[5]}, 64'd0);
    ncyc = 16'd100;
    step("t4.lower");
    chk("t4.commit", {62'd0, bus.gpio_o[5], bus.rise_o[5]}, 64'd3);

    // 5: bypassed pin follows a toggling pad with only the sampling delay.
    do_reset();
    pad = '0; ncyc = 16'd50; en = '1; en[7] = 1'b0;
    for (int k = 0; k < 24; k++) begin
      pad[7] = ~pad[7];
      p7_hist[k] = pad[7];
      step("t5");
      if (k > SL) begin
        chk("t5.follow", {63'd0, bus.gpio_o[7]}, {63'd0, p7_hist[k - SL]});
        chk("t5.pulse", {63'd0, bus.rise_o[7] ^ bus.fall_o[7]}, 64'd1);
      end
    end
    en = '1;

    // 6: all pins rise, reset mid-way, then re-qualify from scratch.
    do_reset();
    pad = '1; ncyc = 16'd8;
    for (int k = 0; k < 4; k++) step("t6.pre");
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step("t6.post");
      if (k == 7 + SL) chk("t6.before", bus.gpio_o, '0);
      if (k == 8 + SL) begin
        chk("t6.gpio", bus.gpio_o, '1);
        chk("t6.rise", bus.rise_o, '1);
      end
    end

    // Randomized phase: sparse pad toggles, occasional bypass and threshold changes.
    do_reset();
    pad = '0; en = '1; ncyc = 16'd3;
    for (int k = 0; k < 400; k++) begin
      pad = pad ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      if ($urandom_range(0, 15) == 0) ncyc = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0)
        en = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on simulation time so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
